// File: rtl/maclauren_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maclauren_pkg : shared types and constants for the maclauren slice |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package maclauren_pkg;

  localparam int X_W   = 8;
  localparam int N_W   = 3;
  localparam int MIN_N = 2;

  localparam int DRAIN_SHORT_DFLT = 3;
  localparam int DRAIN_LONG_DFLT  = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SETUP = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } feeder_state_t;

  // Core pipeline depth depends on the series order.
  function automatic logic [3:0] drain_cycles(input logic [N_W-1:0] n);
    return (n <= 3'd4) ? 4'(DRAIN_SHORT_DFLT) : 4'(DRAIN_LONG_DFLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maclauren_sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maclauren_sample_fifo : synchronous FIFO for feeder X samples      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module maclauren_sample_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/maclauren_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maclauren_feeder : buffers X samples and sequences the core batch  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module maclauren_feeder
  import maclauren_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int BATCH       = 20,
  parameter int DRAIN_SHORT = 3,
  parameter int DRAIN_LONG  = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  input  logic [N_W-1:0] cfg_n,
  output logic           cfg_ready,
  output logic           cfg_error,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_data,
  output logic           in_ready,
  output logic           start,
  output logic [N_W-1:0] N,
  output logic [X_W-1:0] X,
  input  logic           core_ready,
  output logic           busy,
  output logic           done,
  output logic           starve
);

  localparam int CW = $clog2(BATCH + 1);

  feeder_state_t  r_state;
  feeder_state_t  w_next;
  logic [N_W-1:0] r_n;
  logic [N_W-1:0] r_n_out;
  logic [X_W-1:0] r_x;
  logic [CW-1:0]  r_cnt;
  logic [7:0]     r_drain;
  logic           r_cfg_error;

  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [X_W-1:0] w_head;
  logic           w_batch_done;
  logic           w_cfg_ok;
  logic           w_cfg_bad;
  logic           w_start;
  logic           w_done;
  logic           w_busy;
  logic           w_starve;

  assign w_batch_done = (r_cnt == CW'(BATCH));
  assign w_cfg_ok     = cfg_valid && (cfg_n >= N_W'(MIN_N));
  assign w_cfg_bad    = cfg_valid && (cfg_n <  N_W'(MIN_N));
  assign w_push       = in_valid && !w_full;
  // The cycle after the last pop is spent with the counter at BATCH, so no pop then.
  assign w_pop        = (r_state == ST_FEED) && core_ready && !w_empty && !w_batch_done;

  maclauren_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (X_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_done   = 1'b0;
    w_starve = 1'b0;
    w_busy   = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:  if (w_cfg_ok) w_next = ST_START;
      ST_START: begin
        w_start = 1'b1;
        w_next  = ST_SETUP;
      end
      ST_SETUP: w_next = ST_FEED;
      ST_FEED: begin
        w_starve = core_ready && w_empty;
        if (w_batch_done) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (r_drain == 8'd1) w_next = ST_DONE;
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n         <= '0;
      r_n_out     <= '0;
      r_x         <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_cfg_error <= 1'b0;
    end else begin
      r_cfg_error <= (r_state == ST_IDLE) && w_cfg_bad;
      case (r_state)
        ST_IDLE:  if (w_cfg_ok) r_n <= cfg_n;
        ST_SETUP: begin
          r_n_out <= r_n;
          r_cnt   <= '0;
        end
        ST_FEED: begin
          if (w_pop) begin
            r_x   <= w_head;
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_batch_done)
            r_drain <= (r_n <= N_W'(4)) ? 8'(DRAIN_SHORT) : 8'(DRAIN_LONG);
        end
        ST_DRAIN: r_drain <= r_drain - 1'b1;
        default:  ;
      endcase
    end
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign cfg_error = r_cfg_error;
  assign in_ready  = !w_full;
  assign start     = w_start;
  assign N         = r_n_out;
  assign X         = r_x;
  assign busy      = w_busy;
  assign done      = w_done;
  assign starve    = w_starve;

endmodule
`default_nettype wire

// File: tb/tb_maclauren_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_maclauren_feeder : scoreboard bench for the maclauren feeder    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_maclauren_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [2:0] cfg_n;
  logic       cfg_ready;
  logic       cfg_error;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic [2:0] N;
  logic [7:0] X;
  logic       core_ready;
  logic       busy;
  logic       done;
  logic       starve;

  always #5 clk = ~clk;

  maclauren_feeder #(
    .DEPTH       (32),
    .BATCH       (20),
    .DRAIN_SHORT (3),
    .DRAIN_LONG  (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_n      (cfg_n),
    .cfg_ready  (cfg_ready),
    .cfg_error  (cfg_error),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .N          (N),
    .X          (X),
    .core_ready (core_ready),
    .busy       (busy),
    .done       (done),
    .starve     (starve)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_exp;
  int         cyc = 0;
  int         nx = 0;
  int         last_x_cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cnt = 0;
  logic       mon_en = 1'b0;
  logic [7:0] prev_x = 8'h00;
  logic       cr;

  // Every X update is scored against the oldest pushed sample.
  always @(posedge clk) begin
    cr = core_ready;
    #1;
    cyc++;
    if (mon_en) begin
      if (X !== prev_x) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL x_unexpected: got %h, required no update", X);
        end else begin
          m_exp = exp_q.pop_front();
          if (X !== m_exp) begin
            fails++;
            $display("FAIL x_order: got %h, required %h", X, m_exp);
          end
        end
        tests++;
        if (cr !== 1'b1) begin
          fails++;
          $display("FAIL x_without_ready: core_ready %b, required 1", cr);
        end
        nx++;
        last_x_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start === 1'b1) start_cnt++;
    end
    prev_x = X;
  end

  task automatic push_n(input logic [7:0] base, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      exp_q.push_back(base + 8'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg_pulse(input logic [2:0] n);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_n     = n;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    int base;
    base = done_cnt;
    ok   = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk);
      #2;
      if (done_cnt != base) ok = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if ({start, N, X, cfg_error, done, busy, cfg_ready, in_ready, starve} !==
        {1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got st=%b N=%0d X=%h err=%b dn=%b bsy=%b crdy=%b irdy=%b stv=%b, required 0 0 00 0 0 0 1 1 0",
               start, N, X, cfg_error, done, busy, cfg_ready, in_ready, starve);
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_preload();
    int c_acc, n0, s0, d0;
    bit ok;
    core_ready = 1'b1;
    push_n(8'h01, 20);
    n0 = nx; s0 = start_cnt; d0 = done_cnt;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_n     = 3'd3;
    @(posedge clk);
    #2;
    c_acc = cyc;
    tests++;
    if ({start, busy, cfg_ready} !== 3'b110) begin
      fails++;
      $display("FAIL preload_start: got start/busy/cfg_ready=%b%b%b, required 110", start, busy, cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    @(posedge clk);
    #2;
    tests++;
    if (start !== 1'b0) begin
      fails++;
      $display("FAIL preload_start_width: got %b, required 0", start);
    end
    @(posedge clk);
    #2;
    tests++;
    if (N !== 3'd3) begin
      fails++;
      $display("FAIL preload_n: got %0d, required 3", N);
    end
    @(posedge clk);
    #2;
    tests++;
    if (X !== 8'h01) begin
      fails++;
      $display("FAIL preload_first_x: got %h, required 01", X);
    end
    cfg_pulse(3'd7);
    wait_done(100, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL preload_done_timeout: got no done, required done");
    end
    tests++;
    if (last_x_cyc != c_acc + 22) begin
      fails++;
      $display("FAIL preload_last_x_cycle: got %0d, required %0d", last_x_cyc - c_acc, 22);
    end
    tests++;
    if (done_cyc - last_x_cyc != 4) begin
      fails++;
      $display("FAIL preload_done_gap: got %0d, required 4", done_cyc - last_x_cyc);
    end
    tests++;
    if (nx - n0 != 20 || exp_q.size() != 0 || start_cnt - s0 != 1 || done_cnt - d0 != 1 || N !== 3'd3) begin
      fails++;
      $display("FAIL preload_totals: got x=%0d left=%0d starts=%0d dones=%0d N=%0d, required 20 0 1 1 3",
               nx - n0, exp_q.size(), start_cnt - s0, done_cnt - d0, N);
    end
  endtask

  task automatic test_ready_toggle();
    int n0, base;
    bit ok;
    push_n(8'h21, 20);
    core_ready = 1'b1;
    n0   = nx;
    base = done_cnt;
    cfg_pulse(3'd7);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      core_ready = ~core_ready;
      @(posedge clk);
      #2;
      if (done_cnt != base) ok = 1'b1;
    end
    @(negedge clk);
    core_ready = 1'b1;
    @(posedge clk);
    #2;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL toggle_done_timeout: got no done, required done");
    end
    tests++;
    if (done_cyc - last_x_cyc != 8) begin
      fails++;
      $display("FAIL toggle_done_gap: got %0d, required 8", done_cyc - last_x_cyc);
    end
    tests++;
    if (nx - n0 != 20 || exp_q.size() != 0 || N !== 3'd7) begin
      fails++;
      $display("FAIL toggle_totals: got x=%0d left=%0d N=%0d, required 20 0 7", nx - n0, exp_q.size(), N);
    end
  endtask

  task automatic test_starve();
    int n0, bad;
    bit ok;
    core_ready = 1'b1;
    n0  = nx;
    bad = 0;
    cfg_pulse(3'd2);
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (starve !== 1'b1) begin
      fails++;
      $display("FAIL starve_initial: got %b, required 1", starve);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h41 + 8'(i);
      exp_q.push_back(8'h41 + 8'(i));
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      if (starve !== 1'b1) bad++;
      @(posedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL starve_gaps: got %0d gaps without starve, required 0", bad);
    end
    wait_done(50, ok);
    tests++;
    if (!ok || done_cyc - last_x_cyc != 4) begin
      fails++;
      $display("FAIL starve_done: got ok=%0d gap=%0d, required 1 4", ok, done_cyc - last_x_cyc);
    end
    tests++;
    if (nx - n0 != 20 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL starve_count: got x=%0d left=%0d, required 20 0", nx - n0, exp_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int n0, bad;
    bit ok;
    core_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b1) bad++;
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      exp_q.push_back(8'h61 + 8'(i));
    end
    @(negedge clk);
    tests++;
    if (bad != 0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full_ready: got early-low=%0d in_ready=%b, required 0 0", bad, in_ready);
    end
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full_hold: got in_ready=%b, required 0", in_ready);
    end
    n0 = nx;
    cfg_pulse(3'd4);
    wait_done(100, ok);
    tests++;
    if (!ok || done_cyc - last_x_cyc != 4) begin
      fails++;
      $display("FAIL fifo_full_done: got ok=%0d gap=%0d, required 1 4", ok, done_cyc - last_x_cyc);
    end
    tests++;
    if (nx - n0 != 20 || exp_q.size() != 12 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fifo_full_left: got x=%0d left=%0d in_ready=%b, required 20 12 1", nx - n0, exp_q.size(), in_ready);
    end
  endtask

  task automatic test_cfg_error();
    int n0, s0;
    bit ok;
    s0 = start_cnt;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_n     = 3'd1;
    @(posedge clk);
    #2;
    tests++;
    if ({cfg_error, busy, cfg_ready} !== 3'b101) begin
      fails++;
      $display("FAIL cfg_error_pulse: got err/busy/cfg_ready=%b%b%b, required 101", cfg_error, busy, cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    @(posedge clk);
    #2;
    tests++;
    if (cfg_error !== 1'b0) begin
      fails++;
      $display("FAIL cfg_error_width: got %b, required 0", cfg_error);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (start_cnt != s0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cfg_error_nostart: got starts=%0d busy=%b, required 0 0", start_cnt - s0, busy);
    end
    push_n(8'h81, 8);
    n0 = nx;
    cfg_pulse(3'd5);
    wait_done(100, ok);
    tests++;
    if (!ok || done_cyc - last_x_cyc != 8) begin
      fails++;
      $display("FAIL cfg_n5_done: got ok=%0d gap=%0d, required 1 8", ok, done_cyc - last_x_cyc);
    end
    tests++;
    if (nx - n0 != 20 || exp_q.size() != 0 || N !== 3'd5 || start_cnt - s0 != 1) begin
      fails++;
      $display("FAIL cfg_n5_totals: got x=%0d left=%0d N=%0d starts=%0d, required 20 0 5 1",
               nx - n0, exp_q.size(), N, start_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int n0, seen;
    bit ok;
    core_ready = 1'b1;
    push_n(8'hA1, 20);
    n0 = nx;
    cfg_pulse(3'd6);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (nx - n0 == 10) ok = 1'b1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rstmid_reach10: got %0d samples, required 10", nx - n0);
    end
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #2;
    tests++;
    if ({busy, X, N, start, done, cfg_ready, in_ready} !== {1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL rstmid_state: got busy=%b X=%h N=%0d start=%b done=%b, required 0 00 0 0 0",
               busy, X, N, start, done);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #2;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL rstmid_no_done: got %0d cycles with done/busy, required 0", seen);
    end
    mon_en = 1'b1;
    push_n(8'hC1, 20);
    n0 = nx;
    cfg_pulse(3'd6);
    wait_done(100, ok);
    tests++;
    if (!ok || done_cyc - last_x_cyc != 8 || nx - n0 != 20 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_rerun: got ok=%0d gap=%0d x=%0d left=%0d, required 1 8 20 0",
               ok, done_cyc - last_x_cyc, nx - n0, exp_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_n      = 3'd0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    core_ready = 1'b0;
    test_reset();
    test_preload();
    test_ready_toggle();
    test_starve();
    test_fifo_full();
    test_cfg_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
